// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter joining two picorv32 native-bus masters onto one
// downstream port. One transfer outstanding at a time, with an optional response timeout.
module mem_arbiter #(
   parameter int unsigned TIMEOUT       = 255,
   parameter logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic        grant_id,
   output logic        timeout_err
);

   // Counter must be at least one bit wide even when the timeout is disabled
   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic               rr_pri, rr_pri_d;      // master that wins the next tie
   logic               grant_id_d;
   logic               s_valid_d;
   logic [31:0]        s_addr_d, s_wdata_d;
   logic [3:0]         s_wstrb_d;
   logic               m0_ready_d, m1_ready_d;
   logic [31:0]        m0_rdata_d, m1_rdata_d;
   logic               timeout_err_d;
   logic               elig0, elig1, pick, done;
   logic [31:0]        rsp;

   // Next-state and next-output logic
   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      rr_pri_d      = rr_pri;
      grant_id_d    = grant_id;
      s_valid_d     = s_valid;
      s_addr_d      = s_addr;
      s_wdata_d     = s_wdata;
      s_wstrb_d     = s_wstrb;
      m0_ready_d    = 1'b0;
      m1_ready_d    = 1'b0;
      m0_rdata_d    = m0_rdata;
      m1_rdata_d    = m1_rdata;
      timeout_err_d = 1'b0;
      elig0         = m0_valid & ~m0_ready;
      elig1         = m1_valid & ~m1_ready;
      pick          = 1'b0;
      done          = 1'b0;
      rsp           = s_rdata;

      case (state)
         IDLE: begin
            if (elig0 | elig1) begin
               pick       = (elig0 & elig1) ? rr_pri : elig1;
               grant_id_d = pick;
               rr_pri_d   = ~pick;
               s_valid_d  = 1'b1;
               s_addr_d   = pick ? m1_addr  : m0_addr;
               s_wdata_d  = pick ? m1_wdata : m0_wdata;
               s_wstrb_d  = pick ? m1_wstrb : m0_wstrb;
               cnt_d      = '0;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (s_ready) begin
               done = 1'b1;
            end else begin
               cnt_d = cnt + CNT_W'(1);
               if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
                  done          = 1'b1;
                  rsp           = TIMEOUT_RDATA;
                  timeout_err_d = 1'b1;
               end
            end
            if (done) begin
               s_valid_d = 1'b0;
               state_d   = RESP;
               if (grant_id) begin
                  m1_ready_d = 1'b1;
                  m1_rdata_d = rsp;
               end else begin
                  m0_ready_d = 1'b1;
                  m0_rdata_d = rsp;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         rr_pri      <= 1'b0;
         grant_id    <= 1'b0;
         s_valid     <= 1'b0;
         s_addr      <= '0;
         s_wdata     <= '0;
         s_wstrb     <= '0;
         m0_ready    <= 1'b0;
         m1_ready    <= 1'b0;
         m0_rdata    <= '0;
         m1_rdata    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         rr_pri      <= rr_pri_d;
         grant_id    <= grant_id_d;
         s_valid     <= s_valid_d;
         s_addr      <= s_addr_d;
         s_wdata     <= s_wdata_d;
         s_wstrb     <= s_wstrb_d;
         m0_ready    <= m0_ready_d;
         m1_ready    <= m1_ready_d;
         m0_rdata    <= m0_rdata_d;
         m1_rdata    <= m1_rdata_d;
         timeout_err <= timeout_err_d;
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum REQ-state cycles awaiting s_ready; 0 disables the timeout.
REQ-002 Parameter TIMEOUT_RDATA, default 32'hFFFF_FFFF: read data returned on a timed-out transfer.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 m0_valid  input  1  master 0 request (picorv32 native bus).
REQ-006 m0_addr  input  32  master 0 byte address.
REQ-007 m0_wdata  input  32  master 0 write data.
REQ-008 m0_wstrb  input  4  master 0 byte strobes; 0 means read.
REQ-009 m0_ready  output  1  master 0 completion pulse, registered.
REQ-010 m0_rdata  output  32  master 0 read data, registered; valid while m0_ready=1.
REQ-011 m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: master 1 ports, identical widths and meanings to REQ-005..REQ-010.
REQ-012 s_valid  output  1  downstream request, registered.
REQ-013 s_addr / s_wdata / s_wstrb  output  32/32/4  downstream request fields, registered.
REQ-014 s_ready  input  1  downstream one-cycle completion pulse.
REQ-015 s_rdata  input  32  downstream read data, sampled when s_ready=1.
REQ-016 grant_id  output  1  index of the master owning the current or most recent transfer.
REQ-017 timeout_err  output  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-018 FSM states: IDLE, REQ, RESP.
REQ-019 IDLE: master N is eligible when mN_valid=1 and mN_ready=0 in that cycle.
REQ-020 IDLE, exactly one master eligible: grant it.
REQ-021 IDLE, both eligible: grant the master not granted most recently (round robin); after reset, master 0 wins the first tie.
REQ-022 On grant: capture the granted master's addr/wdata/wstrb into s_addr/s_wdata/s_wstrb, set s_valid=1, set grant_id, go to REQ; s_valid is visible the cycle after the request is seen.
REQ-023 REQ: s_valid and s_* fields stay constant; master inputs are ignored.
REQ-024 REQ with s_ready=1: s_valid<=0, mG_rdata<=s_rdata (zero on writes is acceptable, unused), mG_ready<=1, go to RESP.
REQ-025 RESP: mG_ready=1 for exactly one cycle, then 0; go to IDLE; no grant is issued in RESP.
REQ-026 Latency: request seen in IDLE at cycle T and s_ready at T+1+k give mG_ready at T+2+k; best case (k=0) is 2 cycles.
REQ-027 The non-granted master's ready stays 0 throughout; its request waits and is served from the next IDLE.
REQ-028 Timeout counter: cleared on entering REQ, incremented each REQ cycle without s_ready; width is clog2(TIMEOUT+1).
REQ-029 When TIMEOUT>0 and the counter reaches TIMEOUT without s_ready: s_valid<=0, mG_rdata<=TIMEOUT_RDATA, mG_ready<=1, timeout_err=1 for one cycle (aligned with mG_ready), go to RESP.
REQ-030 s_ready in the same cycle the counter reaches TIMEOUT: normal completion wins; no timeout_err.
REQ-031 s_ready received in IDLE or RESP is ignored.
REQ-032 Simultaneous new request and completion: the new request is not considered until IDLE, so at most one transfer is outstanding.
REQ-033 Round-robin state updates only on grant, never on completion or timeout.

Reset
REQ-034 While reset=1, on the clock edge: state=IDLE, s_valid=0, m0_ready=m1_ready=0, timeout_err=0, grant_id=0, round-robin favours master 0, timeout counter=0; rdata and s_* field registers are 0.
REQ-035 Reset during REQ or RESP aborts the transfer silently: no ready pulse and no timeout_err afterwards.

Verification
V1 m0 read 0x0000_0010, downstream s_ready after 3 cycles with 0x1234_5678 -> s_addr=0x10, s_wstrb=0; m0_ready one cycle at T+5 with m0_rdata=0x1234_5678; m1_ready stays 0.
V2 m0 and m1 valid in the same cycle after reset -> m0 served first (grant_id=0), then m1 (grant_id=1); next simultaneous pair -> m0 again, since m1 was granted last.
V3 m1 write 0x1000_0000, wdata 0xA5, wstrb 4'b0001 -> s_wdata=0xA5, s_wstrb=0001 held stable until s_ready; m1_ready one pulse.
V4 TIMEOUT=8, s_ready never asserted -> after 8 REQ cycles s_valid=0, m0_ready=1, m0_rdata=0xFFFF_FFFF, timeout_err=1 for one cycle; next request proceeds normally.
V5 s_ready arrives on the cycle the counter reaches TIMEOUT -> normal rdata returned, timeout_err=0.
V6 reset asserted for one cycle while in REQ -> s_valid=0 next cycle, no mN_ready pulse, FSM in IDLE, master 0 favoured on the next tie.
